// File: rtl/nios_system_pi_response.sv
// Avalon-MM slave that hands a data word to the Pi over a four-phase valid/ack handshake.
// Optional interrupt output and IRQ_MASK register are enabled by defining PI_RESPONSE_IRQ_EN.
module nios_system_pi_response #(
    parameter int DATA_W        = 8,
    parameter int TIMEOUT_W     = 16,
    parameter int TIMEOUT_RESET = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              pi_ack
`ifdef PI_RESPONSE_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   outValid_q, outValid_d;
    logic [TIMEOUT_W-1:0]   count_q, count_d;
    logic [TIMEOUT_W-1:0]   timeoutReg_q, timeoutReg_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;
    logic                   timeoutFlag_q, timeoutFlag_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   ackMeta_q, ackSync_q;

    logic                   wrEn, wrData, wrStatus, wrTimeout;
    logic                   busy, timeoutHit;
    logic                   setDone, setOverrun, setTimeout;
    logic [TIMEOUT_W-1:0]   countInc;
    logic                   unusedWriteBits;

    assign wrEn      = chipselect & ~write_n;
    assign wrData    = wrEn && (address == 2'd0);
    assign wrStatus  = wrEn && (address == 2'd1);
    assign wrTimeout = wrEn && (address == 2'd2);

    assign busy       = (state_q != IDLE);
    assign countInc   = (count_q == '1) ? count_q : count_q + TIMEOUT_W'(1);
    assign timeoutHit = (timeoutReg_q != '0) && (count_q == timeoutReg_q - TIMEOUT_W'(1));

    assign unusedWriteBits = ^writedata;

    assign out_port  = data_q;
    assign out_valid = outValid_q;
    assign readdata  = readdata_q;

    // pi_ack is asynchronous to clk; only the second flop is ever looked at.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ackMeta_q <= 1'b0;
            ackSync_q <= 1'b0;
        end else begin
            ackMeta_q <= pi_ack;
            ackSync_q <= ackMeta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completed handshake takes priority over a timeout on the same edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wrData) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ackSync_q) begin
                    state_d = WAIT_REL;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end
            end
            WAIT_REL: begin
                if (!ackSync_q) begin
                    state_d = IDLE;
                end else if (timeoutHit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d     = data_q;
        outValid_d = outValid_q;
        count_d    = count_q;
        setDone    = 1'b0;
        setOverrun = 1'b0;
        setTimeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wrData) begin
                    data_d     = writedata[DATA_W-1:0];
                    outValid_d = 1'b1;
                    count_d    = '0;
                end
            end
            WAIT_ACK: begin
                setOverrun = wrData;
                count_d    = countInc;
                if (ackSync_q) begin
                    outValid_d = 1'b0;
                    count_d    = '0;
                end else if (timeoutHit) begin
                    outValid_d = 1'b0;
                    setTimeout = 1'b1;
                end
            end
            WAIT_REL: begin
                setOverrun = wrData;
                count_d    = countInc;
                if (!ackSync_q) begin
                    setDone = 1'b1;
                end else if (timeoutHit) begin
                    outValid_d = 1'b0;
                    setTimeout = 1'b1;
                end
            end
            default: begin
                outValid_d = 1'b0;
            end
        endcase
    end

    // A flag being set on the same edge as its write-1-clear stays set.
    always_comb begin
        done_d        = setDone    | (done_q        & ~(wrStatus & writedata[1]));
        overrun_d     = setOverrun | (overrun_q     & ~(wrStatus & writedata[2]));
        timeoutFlag_d = setTimeout | (timeoutFlag_q & ~(wrStatus & writedata[3]));
        timeoutReg_d  = wrTimeout ? writedata[TIMEOUT_W-1:0] : timeoutReg_q;
    end

`ifdef PI_RESPONSE_IRQ_EN
    logic [3:1] irqMask_q, irqMask_d;
    logic       irq_q, irq_d;

    always_comb begin
        irqMask_d = irqMask_q;
        if (wrEn && (address == 2'd3)) begin
            irqMask_d = writedata[3:1];
        end
        irq_d = |({timeoutFlag_q, overrun_q, done_q} & irqMask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqMask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irqMask_q <= irqMask_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        readdata_d = '0;
        unique case (address)
            2'd0: readdata_d = 32'(data_q);
            2'd1: readdata_d = {28'd0, timeoutFlag_q, overrun_q, done_q, busy};
            2'd2: readdata_d = 32'(timeoutReg_q);
`ifdef PI_RESPONSE_IRQ_EN
            2'd3: readdata_d = {28'd0, irqMask_q, 1'b0};
`else
            2'd3: readdata_d = '0;
`endif
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q        <= '0;
            outValid_q    <= 1'b0;
            count_q       <= '0;
            timeoutReg_q  <= TIMEOUT_W'(TIMEOUT_RESET);
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeoutFlag_q <= 1'b0;
            readdata_q    <= '0;
        end else begin
            data_q        <= data_d;
            outValid_q    <= outValid_d;
            count_q       <= count_d;
            timeoutReg_q  <= timeoutReg_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
            timeoutFlag_q <= timeoutFlag_d;
            readdata_q    <= readdata_d;
        end
    end

endmodule

// File: tb/tb_nios_system_pi_response.sv
// Randomized bench for nios_system_pi_response; flags, registers and handshake timing come from a transaction-level model.
// Build with PI_RESPONSE_IRQ_EN defined to exercise the irq output and IRQ_MASK register.
module tb_nios_system_pi_response;

    localparam int DATA_W        = 8;
    localparam int TIMEOUT_W     = 16;
    localparam int TIMEOUT_RESET = 1000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        address = 2'd0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_port;
    logic              out_valid;
    logic              pi_ack = 1'b0;
`ifdef PI_RESPONSE_IRQ_EN
    logic              irq;
`endif

    int checks = 0;
    int passes = 0;

    logic                 expDone, expOverrun, expTimeout;
    logic [TIMEOUT_W-1:0] expTimeoutReg;
    logic [DATA_W-1:0]    expData;
    logic [3:1]           expMask;

    nios_system_pi_response #(
        .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W), .TIMEOUT_RESET(TIMEOUT_RESET)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .out_valid(out_valid), .pi_ack(pi_ack)
`ifdef PI_RESPONSE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [31:0] modelStatus(input logic busy);
        return {28'd0, expTimeout, expOverrun, expDone, busy};
    endfunction

    function automatic logic modelIrq();
        return |({expTimeout, expOverrun, expDone} & expMask);
    endfunction

    task automatic modelReset();
        expDone = 0; expOverrun = 0; expTimeout = 0;
        expTimeoutReg = TIMEOUT_W'(TIMEOUT_RESET);
        expData = '0; expMask = '0;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] value);
        @(negedge clk);
        address = addr;
        @(negedge clk);
        value = readdata;
    endtask

    task automatic clearFlags(input logic [31:0] mask);
        logic [31:0] v;
        busWrite(2'd1, mask);
        if (mask[1]) expDone = 0;
        if (mask[2]) expOverrun = 0;
        if (mask[3]) expTimeout = 0;
        busRead(2'd1, v);
        checkOutput("statusAfterClear", v, modelStatus(1'b0));
    endtask

    // One full four-phase transfer with random data, random ack delays and an optional overrun write.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input bit doOverrun);
        logic [31:0] v;
        busWrite(2'd0, 32'(data));
        expData = data;
        checkOutput("outPortLoad", 32'(out_port), 32'(expData));
        checkOutput("validRaised", 32'(out_valid), 32'd1);
        busRead(2'd1, v);
        checkOutput("statusBusy", v, modelStatus(1'b1));
        if (doOverrun) begin
            busWrite(2'd0, 32'(~data));
            expOverrun = 1;
            checkOutput("outPortHeld", 32'(out_port), 32'(expData));
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pi_ack = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("validBeforeAckSeen", 32'(out_valid), 32'd1);
        @(negedge clk);
        checkOutput("validAfterAck", 32'(out_valid), 32'd0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        pi_ack = 1'b0;
        address = 2'd1;
        repeat (3) @(negedge clk);
        checkOutput("statusStillBusy", readdata, modelStatus(1'b1));
`ifdef PI_RESPONSE_IRQ_EN
        checkOutput("irqBeforeDone", 32'(irq), 32'(modelIrq()));
`endif
        expDone = 1;
        @(negedge clk);
        checkOutput("statusDone", readdata, modelStatus(1'b0));
`ifdef PI_RESPONSE_IRQ_EN
        checkOutput("irqAfterDone", 32'(irq), 32'(modelIrq()));
`endif
        checkOutput("outPortKept", 32'(out_port), 32'(expData));
    endtask

    initial begin
        logic [31:0] v;
        int cnt;
        int t;
        logic [DATA_W-1:0] d;

        modelReset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        checkOutput("resetValid", 32'(out_valid), 32'd0);
        checkOutput("resetOutPort", 32'(out_port), 32'd0);
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), v);
            checkOutput($sformatf("resetRead%0d", a), v, (a == 2) ? 32'(TIMEOUT_RESET) : 32'd0);
        end

        // Random TIMEOUT register traffic, then restore the default.
        for (int i = 0; i < 3; i++) begin
            expTimeoutReg = TIMEOUT_W'($urandom);
            busWrite(2'd2, $urandom & 32'hFFFF_0000 | 32'(expTimeoutReg));
            busRead(2'd2, v);
            checkOutput("timeoutRegRw", v, 32'(expTimeoutReg));
        end
        busWrite(2'd2, 32'(TIMEOUT_RESET));
        expTimeoutReg = TIMEOUT_W'(TIMEOUT_RESET);

        applyStimulus(8'hA5, 1'b1);
        clearFlags(32'h4);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(DATA_W'($urandom), bit'($urandom_range(0, 1)));
            clearFlags($urandom & 32'hF);
            busRead(2'd0, v);
            checkOutput("dataReadback", v, 32'(expData));
        end

        // Timeout with random limit: out_valid stays high exactly TIMEOUT cycles.
        for (int i = 0; i < 3; i++) begin
            t = $urandom_range(3, 8);
            busWrite(2'd2, 32'(t));
            expTimeoutReg = TIMEOUT_W'(t);
            d = DATA_W'($urandom);
            busWrite(2'd0, 32'(d));
            expData = d;
            cnt = 0;
            while (out_valid && cnt < 50) begin
                cnt++;
                @(negedge clk);
            end
            checkOutput("timeoutLength", 32'(cnt), 32'(t));
            expTimeout = 1;
            busRead(2'd1, v);
            checkOutput("statusTimeout", v, modelStatus(1'b0));
            clearFlags(32'h8);
        end

        // Ack seen on the very edge the timeout would fire: the handshake wins.
        t = $urandom_range(4, 9);
        busWrite(2'd2, 32'(t));
        expTimeoutReg = TIMEOUT_W'(t);
        busWrite(2'd0, 32'h5A);
        expData = 8'h5A;
        repeat (t - 3) @(negedge clk);
        pi_ack = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("raceValidHigh", 32'(out_valid), 32'd1);
        @(negedge clk);
        checkOutput("raceValidLow", 32'(out_valid), 32'd0);
        pi_ack = 1'b0;
        repeat (4) @(negedge clk);
        expDone = 1;
        busRead(2'd1, v);
        checkOutput("raceHandshakeWins", v, modelStatus(1'b0));

        // TIMEOUT = 0 never expires.
        busWrite(2'd2, 32'd0);
        expTimeoutReg = '0;
        clearFlags(32'hE);
        busWrite(2'd0, 32'h3C);
        expData = 8'h3C;
        repeat (40) @(negedge clk);
        checkOutput("noTimeoutValid", 32'(out_valid), 32'd1);
        pi_ack = 1'b1;
        repeat (4) @(negedge clk);
        pi_ack = 1'b0;
        repeat (4) @(negedge clk);
        expDone = 1;
        busRead(2'd1, v);
        checkOutput("noTimeoutDone", v, modelStatus(1'b0));

`ifdef PI_RESPONSE_IRQ_EN
        busWrite(2'd2, 32'(TIMEOUT_RESET));
        expTimeoutReg = TIMEOUT_W'(TIMEOUT_RESET);
        clearFlags(32'hE);
        busWrite(2'd3, 32'h2);
        expMask = 3'b001;
        busRead(2'd3, v);
        checkOutput("maskReadback", v, 32'h2);
        applyStimulus(DATA_W'($urandom), 1'b0);
        checkOutput("irqSet", 32'(irq), 32'd1);
        busWrite(2'd1, 32'h2);
        expDone = 0;
        checkOutput("irqHeldOneEdge", 32'(irq), 32'd1);
        @(negedge clk);
        checkOutput("irqCleared", 32'(irq), 32'(modelIrq()));
`else
        busWrite(2'd3, $urandom | 32'hE);
        busRead(2'd3, v);
        checkOutput("addr3ReadsZero", v, 32'd0);
`endif

        // Asynchronous reset while waiting for the ack to be released.
        busWrite(2'd0, 32'hC3);
        pi_ack = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 checkOutput("asyncResetValid", 32'(out_valid), 32'd0);
        checkOutput("asyncResetOutPort", 32'(out_port), 32'd0);
        modelReset();
        pi_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        busRead(2'd1, v);
        checkOutput("postResetStatus", v, modelStatus(1'b0));
        busRead(2'd2, v);
        checkOutput("postResetTimeout", v, 32'(expTimeoutReg));
        busRead(2'd0, v);
        checkOutput("postResetData", v, 32'(expData));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
